// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO rank queue: tuple field layout, stored
// entry type and the sort-key builder.
package pifo_pkg;

    localparam int OVF_LSB   = 28;
    localparam int ROUND_LSB = 17;
    localparam int CLASS_LSB = 12;
    localparam int META_W    = 12;

    localparam int OVF_W   = 2;
    localparam int ROUND_W = 11;
    localparam int CLASS_W = 5;
    localparam int RANK_W  = 19;
    localparam int KEY_W   = OVF_W + ROUND_W + CLASS_W;

    typedef struct packed {
        logic              valid;
        logic [RANK_W-1:0] rank;
        logic [META_W-1:0] meta;
    } pifo_entry_t;

    // Epoch is passed in already rebased so the key stays a plain unsigned compare.
    function automatic logic [KEY_W-1:0] pifo_key(
        input logic [OVF_W-1:0]   epoch,
        input logic [ROUND_W-1:0] round,
        input logic [CLASS_W-1:0] cls
    );
        return {epoch, round, cls};
    endfunction

endpackage

// File: rtl/pifo_key_cmp.sv
// One insert comparator: le=1 when a valid stored entry sorts at or before the
// incoming tuple. PIFO_EPOCH_WRAP_EN selects epoch rebasing against base.
module pifo_key_cmp
    import pifo_pkg::*;
(
    input  pifo_entry_t       entry,
    input  pifo_entry_t       new_entry,
    input  logic [OVF_W-1:0]  base,
    output logic              le
);
    logic [31:0]        e_w;
    logic [31:0]        n_w;
    logic [OVF_W-1:0]   e_ep;
    logic [OVF_W-1:0]   n_ep;
    logic [KEY_W-1:0]   e_key;
    logic [KEY_W-1:0]   n_key;
    logic               unused_bits;

    assign e_w = entry;
    assign n_w = new_entry;

`ifdef PIFO_EPOCH_WRAP_EN
    assign e_ep = e_w[OVF_LSB +: OVF_W] - base;
    assign n_ep = n_w[OVF_LSB +: OVF_W] - base;
`else
    logic unused_base;
    assign unused_base = ^base;
    assign e_ep = e_w[OVF_LSB +: OVF_W];
    assign n_ep = n_w[OVF_LSB +: OVF_W];
`endif

    assign e_key = pifo_key(e_ep, e_w[ROUND_LSB +: ROUND_W], e_w[CLASS_LSB +: CLASS_W]);
    assign n_key = pifo_key(n_ep, n_w[ROUND_LSB +: ROUND_W], n_w[CLASS_LSB +: CLASS_W]);

    // Bit 30 and the meta field never take part in ordering.
    assign unused_bits = ^{e_w[30], e_w[META_W-1:0], n_w[31:30], n_w[META_W-1:0]};

    assign le = entry.valid && (e_key <= n_key);

endmodule

// File: rtl/pifo_rank_queue.sv
// Sorted shift-register PIFO: pushes insert after all entries with key <= new
// key, pops remove index 0. Build option: PIFO_EPOCH_WRAP_EN (see pifo_key_cmp).
module pifo_rank_queue
    import pifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                   clk_dp,
    input  logic                   rst_n,
    input  logic                   tuple_in_pifo_VALID,
    input  logic [31:0]            tuple_in_pifo_DATA,
    input  logic                   pop_req,
    output logic                   pop_valid,
    output logic [31:0]            pop_data,
    output logic [31:0]            wire_out_last_pkt_info,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;

    pifo_entry_t      entry_q  [DEPTH];
    pifo_entry_t      entry_d  [DEPTH];
    pifo_entry_t      src      [DEPTH];
    pifo_entry_t      src_prev [DEPTH];
    pifo_entry_t      new_entry;
    logic [31:0]      last_q, last_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             pop_valid_q, pop_valid_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [DEPTH-1:0] le, le_sel, therm, therm_prev, load, shift;
    logic             push, pop_fire, push_ok;
    logic [OVF_W-1:0] base;

    assign new_entry = tuple_in_pifo_DATA;
    assign base      = last_q[OVF_LSB +: OVF_W];
    assign push      = tuple_in_pifo_VALID & tuple_in_pifo_DATA[31];
    assign pop_fire  = pop_req & ~empty_q;
    // A simultaneous pop frees the slot the push needs, even when full.
    assign push_ok   = push & (~full_q | pop_fire);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            pifo_key_cmp u_cmp (
                .entry     (entry_q[gi]),
                .new_entry (new_entry),
                .base      (base),
                .le        (le[gi])
            );

            // src/le_sel describe the array after the optional pop compaction.
            if (gi == DEPTH - 1) begin : g_tail
                assign src[gi]    = pop_fire ? pifo_entry_t'('0) : entry_q[gi];
                assign le_sel[gi] = ~pop_fire & le[gi];
            end else begin : g_body
                assign src[gi]    = pop_fire ? entry_q[gi+1] : entry_q[gi];
                assign le_sel[gi] = pop_fire ? le[gi+1] : le[gi];
            end

            if (gi == 0) begin : g_head
                assign src_prev[gi] = pifo_entry_t'('0);
            end else begin : g_prev
                assign src_prev[gi] = src[gi-1];
            end

            assign entry_d[gi] = load[gi]  ? new_entry :
                                 shift[gi] ? src_prev[gi] : src[gi];
        end
    endgenerate

    // Prefix-AND keeps the insert mask a clean thermometer even if entries
    // outside the epoch window leave the comparator results non-monotonic.
    always_comb begin
        logic run;
        therm = '0;
        run   = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            run      = run & le_sel[i];
            therm[i] = run;
        end
    end

    assign therm_prev = {therm[DEPTH-2:0], 1'b1};
    assign load       = {DEPTH{push_ok}} & ~therm & therm_prev;
    assign shift      = {DEPTH{push_ok}} & ~therm_prev;

    always_comb begin
        count_d     = count_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop_fire};
        full_d      = (count_d == CW'(DEPTH));
        empty_d     = (count_d == '0);
        pop_valid_d = pop_fire;
        last_d      = pop_fire ? entry_q[0] : last_q;
        drop_d      = drop_q;
        if (push && !push_ok && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk_dp or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            last_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            pop_valid_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            last_q      <= last_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            pop_valid_q <= pop_valid_d;
            drop_q      <= drop_d;
        end
    end

    // The popped tuple and the feedback word are the same register.
    assign pop_valid              = pop_valid_q;
    assign pop_data               = last_q;
    assign wire_out_last_pkt_info = last_q;
    assign full                   = full_q;
    assign empty                  = empty_q;
    assign count                  = count_q;
    assign drop_cnt               = drop_q;

endmodule

// File: tb/tb_pifo_rank_queue.sv
// Directed bench for pifo_rank_queue with a queue-based reference model
// checked every cycle, plus literal expectations from the test plan.
module tb_pifo_rank_queue;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk_dp;
    logic             rst_n;
    logic             vin;
    logic [31:0]      din;
    logic             preq;
    logic             pop_valid;
    logic [31:0]      pop_data;
    logic [31:0]      last_info;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] drop_cnt;

    pifo_rank_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_dp                 (clk_dp),
        .rst_n                  (rst_n),
        .tuple_in_pifo_VALID    (vin),
        .tuple_in_pifo_DATA     (din),
        .pop_req                (preq),
        .pop_valid              (pop_valid),
        .pop_data               (pop_data),
        .wire_out_last_pkt_info (last_info),
        .full                   (full),
        .empty                  (empty),
        .count                  (count),
        .drop_cnt               (drop_cnt)
    );

    initial clk_dp = 1'b0;
    always #5 clk_dp = ~clk_dp;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [31:0] mq[$];
    logic [31:0] m_last;
    bit          m_pv;
    int          m_drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int ovf, input int round, input int cls, input int meta);
        logic [31:0] t;
        t        = '0;
        t[31]    = 1'b1;
        t[29:28] = ovf[1:0];
        t[27:17] = round[10:0];
        t[16:12] = cls[4:0];
        t[11:0]  = meta[11:0];
        return t;
    endfunction

    function automatic int unsigned mkey(input logic [31:0] t, input logic [1:0] b);
        logic [1:0] ep;
`ifdef PIFO_EPOCH_WRAP_EN
        ep = t[29:28] - b;
`else
        ep = t[29:28];
`endif
        return {14'd0, ep, t[27:12]};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_last = '0;
        m_pv   = 1'b0;
        m_drop = 0;
    endtask

    // One clock of queue semantics, using the pre-update base for ordering.
    task automatic model_step();
        logic [1:0] b;
        bit         psh, pp;
        int         pos;
        b   = m_last[29:28];
        psh = vin && din[31];
        pp  = preq && (mq.size() > 0);
        m_pv = pp;
        if (pp) begin
            m_last = mq[0];
            mq.delete(0);
        end
        if (psh) begin
            if (mq.size() < DEPTH) begin
                pos = mq.size();
                for (int i = 0; i < mq.size(); i++) begin
                    if (mkey(mq[i], b) > mkey(din, b)) begin
                        pos = i;
                        break;
                    end
                end
                mq.insert(pos, din);
            end else if (m_drop < (1 << CNT_W) - 1) begin
                m_drop++;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_dp);
            if (rst_n) model_step();
        end
    end

    bit chk_en = 1'b0;
    initial begin
        forever begin
            @(negedge clk_dp);
            if (rst_n && chk_en) begin
                check("count", 32'(count), 32'(mq.size()));
                check("full", 32'(full), 32'(mq.size() == DEPTH));
                check("empty", 32'(empty), 32'(mq.size() == 0));
                check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
                check("pop_valid", 32'(pop_valid), 32'(m_pv));
                check("last_info", last_info, m_last);
                if (m_pv) check("pop_data", pop_data, m_last);
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic p);
        @(negedge clk_dp);
        vin  = v;
        din  = d;
        preq = p;
        @(posedge clk_dp);
        #1;
        $display("cyc t=%0t push=%0b data=%08h pop=%0b -> count=%0d pv=%0b pd=%08h drop=%0d",
                 $time, v, d, p, count, pop_valid, pop_data, drop_cnt);
        vin  = 1'b0;
        din  = '0;
        preq = 1'b0;
    endtask

    task automatic pop_expect(input string name, input int meta);
        cyc(1'b0, '0, 1'b1);
        check({name, "_pv"}, 32'(pop_valid), 32'd1);
        check({name, "_meta"}, 32'(pop_data[11:0]), meta[31:0]);
    endtask

    logic [31:0] w;

    initial begin
        rst_n = 1'b0;
        vin   = 1'b0;
        din   = '0;
        preq  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk_dp);
        @(negedge clk_dp);
        rst_n = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_pv", 32'(pop_valid), 32'd0);
        check("rst_pd", pop_data, 32'd0);
        check("rst_last", last_info, 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        chk_en = 1'b1;

        // Ordering with an equal-key pair.
        cyc(1'b1, mk(0, 5, 0, 1), 1'b0);
        cyc(1'b1, mk(0, 2, 0, 2), 1'b0);
        cyc(1'b1, mk(0, 9, 0, 3), 1'b0);
        cyc(1'b1, mk(0, 2, 0, 4), 1'b0);
        check("ord_count", 32'(count), 32'd4);
        pop_expect("ord0", 2);
        pop_expect("ord1", 4);
        pop_expect("ord2", 1);
        pop_expect("ord3", 3);
        w = last_info;
        check("ord_fb_round", 32'(w[27:17]), 32'd9);

        // Empty corner cases.
        cyc(1'b0, '0, 1'b1);
        check("empty_pop_pv", 32'(pop_valid), 32'd0);
        cyc(1'b1, mk(0, 3, 1, 7), 1'b1);
        check("empty_pp_count", 32'(count), 32'd1);
        check("empty_pp_pv", 32'(pop_valid), 32'd0);

        // Invalid tuple is ignored.
        w = mk(0, 1, 0, 9);
        w[31] = 1'b0;
        cyc(1'b1, w, 1'b0);
        check("inv_count", 32'(count), 32'd1);
        check("inv_drop", 32'(drop_cnt), 32'd0);
        pop_expect("inv_pop", 7);

        // Fill, overflow, push+pop while full, drain.
        for (int i = 0; i < DEPTH + 1; i++) begin
            cyc(1'b1, mk(0, (i * 5) % 11, i % 3, 100 + i), 1'b0);
        end
        check("full_full", 32'(full), 32'd1);
        check("full_drop", 32'(drop_cnt), 32'd1);
        check("full_count", 32'(count), 32'(DEPTH));
        cyc(1'b1, mk(0, 4, 2, 200), 1'b1);
        check("full_pp_count", 32'(count), 32'(DEPTH));
        check("full_pp_drop", 32'(drop_cnt), 32'd1);
        check("full_pp_pv", 32'(pop_valid), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, '0, 1'b1);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Epoch wrap: base becomes 3, then ovf=0 vs ovf=3 entries.
        cyc(1'b1, mk(3, 5, 0, 77), 1'b0);
        pop_expect("ep_base", 77);
        cyc(1'b1, mk(0, 1, 0, 'hA1), 1'b0);
        cyc(1'b1, mk(3, 2047, 0, 'hB2), 1'b0);
`ifdef PIFO_EPOCH_WRAP_EN
        pop_expect("ep_first", 'hB2);
        pop_expect("ep_second", 'hA1);
`else
        pop_expect("ep_first", 'hA1);
        pop_expect("ep_second", 'hB2);
`endif

        // Asynchronous reset while a pop is pending.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, mk(0, 10 - i, 0, 300 + i), 1'b0);
        end
        check("mid_pre_count", 32'(count), 32'd5);
        @(negedge clk_dp);
        preq = 1'b1;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("mid_count", 32'(count), 32'd0);
        check("mid_pv", 32'(pop_valid), 32'd0);
        check("mid_last", last_info, 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        @(posedge clk_dp);
        #1;
        check("mid_pv_edge", 32'(pop_valid), 32'd0);
        @(negedge clk_dp);
        preq  = 1'b0;
        rst_n = 1'b1;

        // Queue is usable again after reset.
        cyc(1'b1, mk(1, 2, 3, 55), 1'b0);
        pop_expect("post_rst", 55);
        cyc(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pifo_rank_queue.md
# pifo_rank_queue

Single-port push-in-first-out queue that sits directly downstream of the WRR rank calculator. It accepts 32-bit rank tuples of the form {valid, rank[18:0], meta[11:0]}, keeps them sorted by rank in a shift-register array, and pops the smallest rank on request. It also publishes the last dequeued tuple, which feeds back to that port's `wire_in_last_pkt_info` input on the rank calculator.

## Interface
- `DEPTH`, 16: number of entries; power of two, 4..64.
- `CNT_W`, 16: width of the drop counter.
- `clk_dp` in 1: data-plane clock; the only clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `tuple_in_pifo_VALID` in 1: push strobe.
- `tuple_in_pifo_DATA` in 32: push tuple. Field map:
  - [31] valid
  - [30] unused
  - [29:28] overflow epoch
  - [27:17] round
  - [16:12] class
  - [11:0] meta
- `pop_req` in 1: dequeue request.
- `pop_valid` out 1: pop result valid.
- `pop_data` out 32: popped tuple.
- `wire_out_last_pkt_info` out 32: last popped tuple, feedback to the rank calculator.
- `full` out 1: queue full.
- `empty` out 1: queue empty.
- `count` out clog2(DEPTH)+1: occupancy.
- `drop_cnt` out CNT_W: saturating count of rejected pushes.

## Operation
- A push is a cycle with VALID=1 and DATA[31]=1. If VALID=1 and DATA[31]=0, the cycle is ignored.
- **Sort key:** key = {(ovf − base) mod 4, round, class}, where base = `wire_out_last_pkt_info`[29:28]. Bit [30] is excluded from comparison.
- **Insert position:** after every entry whose key is ≤ the new key. Equal keys therefore dequeue in arrival (FIFO) order.
- **Pop:** when `pop_req`=1 and not empty, the head (index 0) is removed and all entries shift toward the head.
- **Pop on empty:** no effect; `pop_valid` stays 0.
- **Full, push only:** the push is dropped and `drop_cnt` increments, saturating at all-ones.
- **Full, push and pop in the same cycle:** the pop removes the head and the push is inserted into the compacted array. The push is accepted and no drop is counted.
- **Empty, push and pop in the same cycle:** there is no bypass. The push is stored, the pop is ignored, and `pop_valid`=0.
- **Feedback:** on every pop, `wire_out_last_pkt_info` is loaded with the popped tuple. The new base applies to comparisons from the next cycle on.
- **Epoch window:** entries must lie within 3 epochs ahead of base. Outside that window the queue stays intact, but ordering is unspecified.
- **Registered outputs:** `count`, `full` and `empty` are registered and reflect the post-update state.

## Timing
- **Push:** accepted in cycle N. The entry is visible to a pop issued in cycle N+1.
- **Pop:** `pop_req` in cycle N gives `pop_valid`=1 with `pop_data` in cycle N+1. `pop_valid` is a one-cycle pulse per accepted pop; back-to-back pops give one pulse per cycle.
- **Feedback timing:** `wire_out_last_pkt_info` updates in the same cycle as `pop_valid`.
- **Reset values:**
  - all entries invalid, `count`=0
  - `empty`=1, `full`=0
  - `pop_valid`=0, `pop_data`=0
  - `wire_out_last_pkt_info`=0, so base=0
  - `drop_cnt`=0
- **Reset mid-operation:** asynchronous. All entries and counters clear immediately, and a pending pop does not produce `pop_valid`.
- **Critical path:** DEPTH parallel comparators → thermometer insert mask → per-entry 3:1 mux (hold / shift / load).

## Configuration
- Macro: `PIFO_EPOCH_WRAP_EN`.
- **Defined:** the sort key uses (ovf − base) mod 4, as above. Ranks from epoch 0 sort after epoch 3 when base=3.
- **Undefined:** the key is {ovf, round, class} as a plain unsigned value, with no dependence on base. The feedback output is still produced.

## Structure
- **Shared package `pifo_pkg`:**
  - field offsets and widths: `OVF_LSB`=28, `ROUND_LSB`=17, `CLASS_LSB`=12, `META_W`=12
  - a `pifo_entry_t` struct {valid, rank, meta}
  - a key function
- **Sub-module `pifo_key_cmp`:** combinational; takes (entry, new, base) and returns le. It is instantiated DEPTH times and holds the `PIFO_EPOCH_WRAP_EN` switch.

## Test plan
- **Ordering:** push ranks with round 5, 2, 9, 2 (class 0, meta 1..4), then 4 pops → meta order 2, 4, 1, 3; `wire_out_last_pkt_info`[27:17] = 9 after the last pop.
- **Full / drop:** DEPTH=16, push 17 entries → `full`=1, `drop_cnt`=1, `count`=16. Push+pop in the same cycle while full → `count` stays 16, `drop_cnt` stays 1.
- **Empty:** pop on empty → no `pop_valid`. Push+pop in the same cycle on empty → `count`=1, `pop_valid`=0.
- **Epoch wrap (`PIFO_EPOCH_WRAP_EN`):** pop an ovf=3 entry so base=3, then push (ovf=0, round 1) and (ovf=3, round 2047) → the ovf=3 entry pops first. With the macro undefined, the ovf=0 entry pops first.
- **Reset mid-operation:** 5 entries queued, assert `rst_n` low while `pop_req`=1 → `count`=0, `pop_valid`=0, `wire_out_last_pkt_info`=0.
- **Invalid tuple:** VALID=1 with DATA[31]=0 → `count` unchanged, `drop_cnt` unchanged.
